// File: rtl/fifo_drain_ctrl.sv
// Drain controller for two fill-counted FIFOs: picks a FIFO to offer to the AXI slave
// (full burst at threshold, partial burst on idle timeout), tracks the burst and raises irq.
module fifo_drain_ctrl #(
   parameter int unsigned DEPTH_W = 5,
   parameter int unsigned THRESH  = 16,
   parameter int unsigned TMO_W   = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [DEPTH_W-1:0] fifo1_count,
   input  logic [DEPTH_W-1:0] fifo2_count,
   input  logic               fifo_rd_en,
   input  logic               fifo_choose,
   input  logic               err_clr,
   output logic [7:0]         int_status,
   output logic               irq
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]       state;
   logic             grant;
   logic             valid;
   logic             partial;
   logic             err;
   logic [3:0]       len;
   logic [4:0]       beat_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic             last_grant;

   logic             elig1, elig2, any_elig;
   logic             nonempty1, nonempty2, any_nonempty;
   logic             tmo_qual, fire_tmo;
   logic             start_grant;
   logic [DEPTH_W-1:0] start_cnt;
   logic [31:0]      start_cnt32;
   logic [3:0]       start_len;
   logic             busy, match_rd, bad_rd, done_txn;

   // Grant selection: threshold eligibility beats timeout; ties go to the FIFO not served last.
   always_comb begin
      elig1        = enable && (32'(fifo1_count) >= THRESH);
      elig2        = enable && (32'(fifo2_count) >= THRESH);
      any_elig     = elig1 || elig2;
      nonempty1    = (fifo1_count != '0);
      nonempty2    = (fifo2_count != '0);
      any_nonempty = nonempty1 || nonempty2;
      tmo_qual     = enable && any_nonempty && !any_elig;
      fire_tmo     = tmo_qual && (&tmo_cnt);

      start_grant = 1'b0;
      if (any_elig)
         start_grant = (elig1 && elig2) ? ~last_grant : elig2;
      else
         start_grant = (nonempty1 && nonempty2) ? ~last_grant : nonempty2;

      start_cnt   = start_grant ? fifo2_count : fifo1_count;
      start_cnt32 = 32'(start_cnt);
      start_len   = 4'd15;
      if (start_cnt32 < 32'd16)
         start_len = 4'(start_cnt32 - 32'd1);
   end

   // Read-strobe qualification; a completing beat is the one that makes the count reach len+1.
   always_comb begin
      busy     = (state != ST_IDLE);
      match_rd = fifo_rd_en && (fifo_choose == grant);
      bad_rd   = busy && fifo_rd_en && (fifo_choose != grant);
      done_txn = 1'b0;
      if (match_rd) begin
         if (state == ST_REQ)
            done_txn = enable && (len == 4'd0);
         else if (state == ST_DRAIN)
            done_txn = (beat_cnt == {1'b0, len});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         grant      <= 1'b0;
         valid      <= 1'b0;
         partial    <= 1'b0;
         err        <= 1'b0;
         len        <= 4'd0;
         beat_cnt   <= 5'd0;
         tmo_cnt    <= '0;
         last_grant <= 1'b1;
         irq        <= 1'b0;
      end else begin
         err <= (err & ~err_clr) | bad_rd;
         if (done_txn) begin
            state      <= ST_IDLE;
            valid      <= 1'b0;
            partial    <= 1'b0;
            len        <= 4'd0;
            beat_cnt   <= 5'd0;
            tmo_cnt    <= '0;
            last_grant <= grant;
            irq        <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (any_elig || fire_tmo) begin
                     state    <= ST_REQ;
                     grant    <= start_grant;
                     valid    <= 1'b1;
                     partial  <= ~any_elig;
                     len      <= start_len;
                     beat_cnt <= 5'd0;
                     tmo_cnt  <= '0;
                     irq      <= 1'b1;
                  end else if (tmo_qual) begin
                     tmo_cnt <= tmo_cnt + 1'b1;
                  end else begin
                     tmo_cnt <= '0;
                  end
               end
               ST_REQ: begin
                  // Losing enable withdraws the offer without crediting the FIFO as served.
                  if (!enable) begin
                     state   <= ST_IDLE;
                     valid   <= 1'b0;
                     partial <= 1'b0;
                     len     <= 4'd0;
                     irq     <= 1'b0;
                  end else if (match_rd) begin
                     state    <= ST_DRAIN;
                     beat_cnt <= 5'd1;
                     irq      <= 1'b0;
                  end
               end
               ST_DRAIN: begin
                  if (match_rd)
                     beat_cnt <= beat_cnt + 5'd1;
               end
               default: begin
                  state <= ST_IDLE;
                  valid <= 1'b0;
                  irq   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign int_status = {len, err, partial, grant, valid};

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Scoreboard bench for fifo_drain_ctrl: directed scenarios plus random traffic, each cycle's
// expected {irq, int_status} comes from a transaction-level model and is checked by a monitor.
module tb_fifo_drain_ctrl;

   localparam int DEPTH_W    = 5;
   localparam int THRESH     = 16;
   localparam int TMO_W      = 10;
   localparam int TMO_CYCLES = 1 << TMO_W;

   logic               clk;
   logic               rst_n;
   logic               enable;
   logic [DEPTH_W-1:0] fifo1_count;
   logic [DEPTH_W-1:0] fifo2_count;
   logic               fifo_rd_en;
   logic               fifo_choose;
   logic               err_clr;
   logic [7:0]         int_status;
   logic               irq;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];

   // Model of the current offer: a burst of m_len+1 beats from FIFO m_fifo.
   bit m_active, m_draining, m_fifo, m_last, m_partial, m_err;
   int m_len, m_done, m_idle;

   fifo_drain_ctrl #(.DEPTH_W(DEPTH_W), .THRESH(THRESH), .TMO_W(TMO_W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .fifo1_count(fifo1_count), .fifo2_count(fifo2_count),
      .fifo_rd_en(fifo_rd_en), .fifo_choose(fifo_choose), .err_clr(err_clr),
      .int_status(int_status), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no finish, want finish before 1ms");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [8:0] exp);
      checks++;
      if ({irq, int_status} !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got irq=%0b status=%02h, want irq=%0b status=%02h",
                  name, irq, int_status, exp[8], exp[7:0]);
      end
   endtask

   function automatic logic [8:0] modelOut();
      logic [3:0] l;
      l = m_active ? 4'(m_len) : 4'd0;
      return {m_active && !m_draining, l, m_err, m_active && m_partial, m_fifo, m_active};
   endfunction

   task automatic modelReset();
      m_active = 0; m_draining = 0; m_fifo = 0; m_last = 1; m_partial = 0; m_err = 0;
      m_len = 0; m_done = 0; m_idle = 0;
   endtask

   function automatic bit pickFifo(bit a, bit b);
      return (a && b) ? !m_last : b;
   endfunction

   task automatic startTxn(bit f, int c1, int c2, bit part);
      int cnt;
      cnt = f ? c2 : c1;
      m_len = ((cnt > 16) ? 16 : cnt) - 1;
      m_active = 1; m_draining = 0; m_done = 0; m_partial = part; m_fifo = f; m_idle = 0;
   endtask

   task automatic finishTxn();
      m_active = 0; m_draining = 0; m_last = m_fifo; m_done = 0;
   endtask

   task automatic modelStep(bit en, int c1, int c2, bit rd, bit ch, bit clr);
      bit bad, hit, e1, e2, n1, n2;
      bad = rd && m_active && (ch != m_fifo);
      hit = rd && m_active && (ch == m_fifo);
      m_err = (m_err && !clr) || bad;
      if (!m_active) begin
         e1 = en && (c1 >= THRESH);
         e2 = en && (c2 >= THRESH);
         n1 = (c1 != 0);
         n2 = (c2 != 0);
         if (e1 || e2) begin
            startTxn(pickFifo(e1, e2), c1, c2, 0);
         end else if (en && (n1 || n2)) begin
            m_idle++;
            if (m_idle == TMO_CYCLES) startTxn(pickFifo(n1, n2), c1, c2, 1);
         end else begin
            m_idle = 0;
         end
      end else if (!m_draining) begin
         if (!en) begin
            m_active = 0;
         end else if (hit) begin
            m_done = 1;
            if (m_done == m_len + 1) finishTxn();
            else m_draining = 1;
         end
      end else if (hit) begin
         m_done++;
         if (m_done == m_len + 1) finishTxn();
      end
   endtask

   // Drives one cycle's inputs in the low clock phase and queues the expected post-edge outputs.
   task automatic applyStimulus(input bit en, input int c1, input int c2,
                                input bit rd, input bit ch, input bit clr);
      enable      = en;
      fifo1_count = DEPTH_W'(c1);
      fifo2_count = DEPTH_W'(c2);
      fifo_rd_en  = rd;
      fifo_choose = ch;
      err_clr     = clr;
      modelStep(en, c1, c2, rd, ch, clr);
      exp_q.push_back(modelOut());
      @(negedge clk);
   endtask

   task automatic pulseReset();
      #1 rst_n = 1'b0;
      #1 checkOutput("reset_async", 9'h000);
      modelReset();
      #1 rst_n = 1'b1;
   endtask

   // Monitor: compares every post-edge output against the oldest queued expectation.
   initial begin
      logic [8:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("scoreboard", e);
         end
      end
   end

   initial begin
      bit en, rd, ch, clr;
      int r1, r2;
      rst_n = 1'b1; enable = 0; fifo1_count = '0; fifo2_count = '0;
      fifo_rd_en = 0; fifo_choose = 0; err_clr = 0;
      modelReset();
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_state", 9'h000);
      #1 rst_n = 1'b1;

      // Both at threshold: FIFO1 first, then FIFO2.
      applyStimulus(1, 16, 16, 0, 0, 0);
      checkOutput("rr_first_fifo1", 9'h1F1);
      for (int i = 0; i < 16; i++) applyStimulus(1, 16, 16, 1, 0, 0);
      checkOutput("rr_drain1_idle", 9'h000);
      applyStimulus(1, 16, 16, 0, 0, 0);
      checkOutput("rr_second_fifo2", 9'h1F3);
      for (int i = 0; i < 16; i++) applyStimulus(1, (i == 15) ? 0 : 16, (i == 15) ? 0 : 16, 1, 1, 0);
      checkOutput("rr_drain2_idle", 9'h002);

      // Single full burst from FIFO1 after a fresh reset.
      pulseReset();
      applyStimulus(1, 16, 0, 0, 0, 0);
      checkOutput("full_grant_latency", 9'h1F1);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1, (i == 15) ? 0 : 16, 0, 1, 0, 0);
         if (i == 0) checkOutput("first_beat_irq_low", 9'h0F1);
         if (i == 14) checkOutput("beat15_still_busy", 9'h0F1);
      end
      checkOutput("full_drain_idle", 9'h000);

      // Idle timeout on a partially filled FIFO2.
      for (int i = 1; i <= TMO_CYCLES; i++) begin
         applyStimulus(1, 0, 3, 0, 0, 0);
         if (i == TMO_CYCLES - 1) checkOutput("no_irq_before_timeout", 9'h000);
      end
      checkOutput("timeout_partial_fifo2", 9'h127);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, (i == 2) ? 0 : 3, 1, 1, 0);
      checkOutput("partial_drain_idle", 9'h002);

      // Wrong-FIFO reads flag err without counting; err_clr loses to a simultaneous error.
      applyStimulus(1, 16, 0, 0, 0, 0);
      checkOutput("err_scn_grant", 9'h1F1);
      for (int i = 0; i < 5; i++) applyStimulus(1, 16, 0, 1, 0, 0);
      applyStimulus(1, 16, 0, 1, 1, 0);
      checkOutput("bad_read_sets_err", 9'h0F9);
      applyStimulus(1, 16, 0, 1, 1, 1);
      checkOutput("err_clr_vs_new_err", 9'h0F9);
      applyStimulus(1, 16, 0, 0, 0, 1);
      checkOutput("err_clr_clears", 9'h0F1);
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1, (i == 10) ? 0 : 16, 0, 1, 0, 0);
         if (i == 9) checkOutput("bad_read_not_counted", 9'h0F1);
      end
      checkOutput("err_scn_idle", 9'h000);

      // enable withdrawn in REQ aborts; withdrawn in DRAIN does not.
      applyStimulus(1, 16, 0, 0, 0, 0);
      applyStimulus(0, 16, 0, 0, 0, 0);
      checkOutput("enable_drop_req", 9'h000);
      applyStimulus(1, 16, 0, 0, 0, 0);
      checkOutput("enable_rearm", 9'h1F1);
      applyStimulus(1, 16, 0, 1, 0, 0);
      for (int i = 0; i < 15; i++) begin
         applyStimulus(0, (i == 14) ? 0 : 16, 0, 1, 0, 0);
         if (i == 13) checkOutput("drain_while_disabled", 9'h0F1);
      end
      checkOutput("drain_done_disabled", 9'h000);

      // Reset mid-drain, then fresh arbitration (last_grant back to FIFO2).
      applyStimulus(1, 16, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 16, 0, 1, 0, 0);
      pulseReset();
      applyStimulus(1, 16, 16, 0, 0, 0);
      checkOutput("rearm_after_reset", 9'h1F1);
      for (int i = 0; i < 16; i++) applyStimulus(1, (i == 15) ? 0 : 16, (i == 15) ? 0 : 16, 1, 0, 0);

      // Timeout with both FIFOs nonempty alternates from the last served FIFO1.
      for (int i = 0; i < TMO_CYCLES; i++) applyStimulus(1, 2, 5, 0, 0, 0);
      checkOutput("timeout_rr_fifo2", 9'h147);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, (i == 4) ? 0 : 5, 1, 1, 0);

      // Random traffic against the model.
      r1 = 0; r2 = 0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) r1 = int'($urandom_range(0, 31));
         if ($urandom_range(0, 7) == 0) r2 = int'($urandom_range(0, 31));
         en  = ($urandom_range(0, 19) != 0);
         rd  = ($urandom_range(0, 1) == 1);
         ch  = (m_active && $urandom_range(0, 6) != 0) ? m_fifo : ($urandom_range(0, 1) == 1);
         clr = ($urandom_range(0, 15) == 0);
         applyStimulus(en, r1, r2, rd, ch, clr);
      end

      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_drain_ctrl.md
FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 Parameter DEPTH_W, 5, width of each FIFO fill-count input.
REQ-002 Parameter THRESH, 16, fill level that triggers a full-burst request; range 1..16, so len fits arlen[3:0].
REQ-003 Parameter TMO_W, 10, timeout counter width; timeout fires after 2**TMO_W idle cycles.
REQ-004 clk  input  1  block clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  soft enable; 0 = no new grants.
REQ-007 fifo1_count  input  DEPTH_W  current fill level of FIFO1.
REQ-008 fifo2_count  input  DEPTH_W  current fill level of FIFO2.
REQ-009 fifo_rd_en  input  1  read strobe driven by the AXI slave to the FIFOs.
REQ-010 fifo_choose  input  1  FIFO select from the AXI slave; 0 = FIFO1, 1 = FIFO2.
REQ-011 err_clr  input  1  single-cycle pulse that clears the sticky error bit.
REQ-012 int_status  output  8  value of the INT_STATUS register: [0] valid, [1] grant, [2] partial, [3] err, [7:4] len.
REQ-013 irq  output  1  level interrupt to the host.

Function
REQ-014 The FSM shall have three states: IDLE, REQ and DRAIN; all outputs and state shall be registered.
REQ-015 In IDLE with enable=1, a FIFO is eligible at threshold when its count >= THRESH.
REQ-016 If one or more FIFOs are eligible, the FSM shall move to REQ on the next edge and grant one FIFO round-robin.
REQ-017 Round-robin rule: when both FIFOs are eligible, grant the FIFO not granted last; last_grant resets to FIFO2, so FIFO1 wins first.
REQ-018 Timeout counter: increments in IDLE while enable=1, at least one count is nonzero and neither FIFO is at threshold; clears otherwise.
REQ-019 On timeout the FSM shall move to REQ, granting round-robin among nonempty FIFOs, with partial=1.
REQ-020 On entry to REQ the block shall latch len = min(count, 16) - 1 for the granted FIFO, set valid=1 and set grant.
REQ-021 irq shall be 1 exactly while state is REQ.
REQ-022 In REQ, the first fifo_rd_en with fifo_choose == grant shall count as beat 1 and move the FSM to DRAIN; irq falls on the same edge.
REQ-023 In DRAIN, each fifo_rd_en with matching fifo_choose shall increment a 5-bit beat counter.
REQ-024 When the beat count reaches len+1, the FSM shall return to IDLE on that edge, clear valid, partial and len, update last_grant and clear the timeout counter.
REQ-025 fifo_rd_en with fifo_choose != grant while in REQ or DRAIN shall be ignored for counting and shall set err=1.
REQ-026 err is sticky; err_clr clears it; if err_clr and a new error occur in the same cycle, err shall remain 1.
REQ-027 enable=0 in IDLE shall hold IDLE; enable=0 in REQ shall return to IDLE next edge with valid=0; enable=0 in DRAIN shall let the drain complete normally.
REQ-028 Counts that drop (external reads) while in REQ shall not alter the latched len.
REQ-029 A grant shall never be issued to an empty FIFO.
REQ-030 Minimum latency from threshold reached to irq=1 shall be 1 cycle.

Reset
REQ-031 On rst_n=0 the block shall asynchronously reset to: state IDLE, int_status=8'h00, irq=0, beat counter 0, timeout counter 0, last_grant = FIFO2.
REQ-032 Reset asserted mid-REQ or mid-DRAIN shall abort the transaction with no residual state.

Verification
REQ-033 fifo1_count=16, enable=1 -> next cycle irq=1, int_status=8'hF1; 16 reads with fifo_choose=0 -> IDLE, int_status=8'h00, irq=0.
REQ-034 Both counts=16 -> FIFO1 granted (status 8'hF1); after its drain completes -> FIFO2 granted (status 8'hF3).
REQ-035 fifo2_count=3 held for 1024 cycles -> irq=1, int_status=8'h27 (len=2, partial, grant=FIFO2, valid); drain of 3 beats -> IDLE.
REQ-036 During DRAIN of FIFO1, one read with fifo_choose=1 -> err=1 and beat count unchanged; err_clr pulse -> err=0.
REQ-037 enable dropped while in REQ -> IDLE and irq=0 next cycle; enable dropped in DRAIN -> drain completes first.
REQ-038 rst_n pulsed mid-DRAIN -> int_status=8'h00 and irq=0 immediately; re-arms normally after release.
